// File: rtl/c_mod_counter_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : c_mod_counter_mc_pkg
// Description : Shared range helpers and saturation-mode constants for the
//               modulo counter bank.
// Revision    : 1.0 - initial release
// ============================================================================
package c_mod_counter_mc_pkg;

    localparam int unsigned c_sat_mode_wrap = 0;
    localparam int unsigned c_sat_mode_sat  = 1;

    // Smallest r with (1 << r) >= v.
    function automatic int unsigned clogb(input longint unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 64; i++) begin
            if ((64'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Number of leading bits (of w) that a and b share.
    function automatic int unsigned common_prefix_len(input longint unsigned a,
                                                      input longint unsigned b,
                                                      input int unsigned     w);
        int unsigned n;
        bit          same;
        n    = 0;
        same = 1'b1;
        for (int i = 63; i >= 0; i--) begin
            if (i < int'(w) && same) begin
                if (a[i] == b[i]) begin
                    n = n + 1;
                end else begin
                    same = 1'b0;
                end
            end
        end
        return n;
    endfunction

endpackage : c_mod_counter_mc_pkg
`default_nettype wire

// File: rtl/c_mod_step.sv
`default_nettype none
// ============================================================================
// Module      : c_mod_step
// Description : Combinational next-state logic for one modulo counter channel.
// Revision    : 1.0 - initial release
// ============================================================================
module c_mod_step
    import c_mod_counter_mc_pkg::*;
#(
    parameter int unsigned width     = 4,
    parameter int unsigned min_value = 0,
    parameter int unsigned max_value = 15,
    parameter int unsigned sat_mode  = c_sat_mode_wrap
) (
    input  logic [width-1:0] i_count,
    input  logic             i_incr,
    input  logic             i_decr,
    input  logic             i_load,
    input  logic [width-1:0] i_load_data,
    output logic [width-1:0] o_next_count,
    output logic             o_wrap,
    output logic             o_load_err
);

    localparam logic [width-1:0] c_min = width'(min_value);
    localparam logic [width-1:0] c_max = width'(max_value);

    logic w_lo_ok;
    logic w_hi_ok;

    // Bounds that coincide with the natural limits of the word need no compare.
    generate
        if (min_value == 0) begin : g_lo_free
            assign w_lo_ok = 1'b1;
        end else begin : g_lo_chk
            assign w_lo_ok = (i_load_data >= c_min);
        end
        if (64'(max_value) == ((64'd1 << width) - 64'd1)) begin : g_hi_free
            assign w_hi_ok = 1'b1;
        end else begin : g_hi_chk
            assign w_hi_ok = (i_load_data <= c_max);
        end
    endgenerate

    always_comb begin
        o_next_count = i_count;
        o_wrap       = 1'b0;
        o_load_err   = 1'b0;
        if (i_load) begin
            if (w_lo_ok && w_hi_ok) begin
                o_next_count = i_load_data;
            end else begin
                o_next_count = c_min;
                o_load_err   = 1'b1;
            end
        end else if (i_incr && !i_decr) begin
            if (i_count == c_max) begin
                o_wrap = 1'b1;
                if (sat_mode == c_sat_mode_wrap) begin
                    o_next_count = c_min;
                end
            end else begin
                o_next_count = i_count + width'(1);
            end
        end else if (i_decr && !i_incr) begin
            if (i_count == c_min) begin
                o_wrap = 1'b1;
                if (sat_mode == c_sat_mode_wrap) begin
                    o_next_count = c_max;
                end
            end else begin
                o_next_count = i_count - width'(1);
            end
        end
    end

endmodule : c_mod_step
`default_nettype wire

// File: rtl/c_mod_counter_mc.sv
`default_nettype none
// ============================================================================
// Module      : c_mod_counter_mc
// Description : Bank of independent registered modulo counters with
//               wrap/saturate, parallel load and boundary flags.
// Revision    : 1.0 - initial release
// ============================================================================
module c_mod_counter_mc
    import c_mod_counter_mc_pkg::*;
#(
    parameter int unsigned num_channels = 4,
    parameter int unsigned width        = 4,
    parameter int unsigned min_value    = 0,
    parameter int unsigned max_value    = (1 << width) - 1,
    parameter int unsigned reset_value  = min_value,
    parameter int unsigned sat_mode     = c_sat_mode_wrap
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [num_channels-1:0]       load,
    input  logic [num_channels*width-1:0] load_data,
    input  logic [num_channels-1:0]       incr,
    input  logic [num_channels-1:0]       decr,
    output logic [num_channels*width-1:0] count,
    output logic [num_channels-1:0]       at_min,
    output logic [num_channels-1:0]       at_max,
    output logic [num_channels-1:0]       wrapped,
    output logic [num_channels-1:0]       load_err
);

    localparam logic [width-1:0] c_min = width'(min_value);
    localparam logic [width-1:0] c_max = width'(max_value);
    localparam logic [width-1:0] c_rst = width'(reset_value);

    generate
        if (width < 1) begin : g_err_width
            $error("c_mod_counter_mc: width must be at least 1");
        end
        if (max_value < min_value) begin : g_err_order
            $error("c_mod_counter_mc: max_value below min_value");
        end
        if (clogb(64'(max_value) + 64'd1) > width) begin : g_err_fit
            $error("c_mod_counter_mc: max_value does not fit in width bits");
        end
        if (reset_value < min_value || reset_value > max_value) begin : g_err_reset
            $error("c_mod_counter_mc: reset_value outside [min_value,max_value]");
        end
        if (sat_mode != c_sat_mode_wrap && sat_mode != c_sat_mode_sat) begin : g_err_mode
            $error("c_mod_counter_mc: unsupported sat_mode");
        end
    endgenerate

    logic [num_channels-1:0][width-1:0] r_count;
    logic [num_channels-1:0]            r_at_min;
    logic [num_channels-1:0]            r_at_max;
    logic [num_channels-1:0]            r_wrapped;
    logic [num_channels-1:0]            r_load_err;

    logic [num_channels-1:0][width-1:0] w_next;
    logic [num_channels-1:0]            w_wrap;
    logic [num_channels-1:0]            w_load_err;

    generate
        for (genvar c = 0; c < num_channels; c++) begin : g_ch
            c_mod_step #(
                .width     (width),
                .min_value (min_value),
                .max_value (max_value),
                .sat_mode  (sat_mode)
            ) u_step (
                .i_count      (r_count[c]),
                .i_incr       (incr[c]),
                .i_decr       (decr[c]),
                .i_load       (load[c]),
                .i_load_data  (load_data[c*width +: width]),
                .o_next_count (w_next[c]),
                .o_wrap       (w_wrap[c]),
                .o_load_err   (w_load_err[c])
            );
        end
    endgenerate

    // Flags are registered from the next count so they align with count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count    <= {num_channels{c_rst}};
            r_at_min   <= {num_channels{c_rst == c_min}};
            r_at_max   <= {num_channels{c_rst == c_max}};
            r_wrapped  <= '0;
            r_load_err <= '0;
        end else begin
            r_count    <= w_next;
            r_wrapped  <= w_wrap;
            r_load_err <= w_load_err;
            for (int c = 0; c < int'(num_channels); c++) begin
                r_at_min[c] <= (w_next[c] == c_min);
                r_at_max[c] <= (w_next[c] == c_max);
            end
        end
    end

    assign count    = r_count;
    assign at_min   = r_at_min;
    assign at_max   = r_at_max;
    assign wrapped  = r_wrapped;
    assign load_err = r_load_err;

endmodule : c_mod_counter_mc
`default_nettype wire

// File: tb/tb_c_mod_counter_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_c_mod_counter_mc
// Description : Scoreboard bench: wrap (3..9), saturate (3..9) and
//               power-of-two (0..7, width 3) counter banks against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_c_mod_counter_mc;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] load  = '0;
    logic [1:0] incr  = '0;
    logic [1:0] decr  = '0;
    logic [7:0] ldd   = '0;
    logic [5:0] ldd_p;

    logic [7:0] cnt_w, cnt_s;
    logic [5:0] cnt_p;
    logic [1:0] amin_w, amax_w, wr_w, le_w;
    logic [1:0] amin_s, amax_s, wr_s, le_s;
    logic [1:0] amin_p, amax_p, wr_p, le_p;

    assign ldd_p = {ldd[6:4], ldd[2:0]};

    always #5 clk = ~clk;

    c_mod_counter_mc #(.num_channels(2), .width(4), .min_value(3), .max_value(9),
                       .reset_value(3), .sat_mode(0)) dut_w (
        .clk(clk), .reset(reset), .load(load), .load_data(ldd), .incr(incr), .decr(decr),
        .count(cnt_w), .at_min(amin_w), .at_max(amax_w), .wrapped(wr_w), .load_err(le_w));

    c_mod_counter_mc #(.num_channels(2), .width(4), .min_value(3), .max_value(9),
                       .reset_value(3), .sat_mode(1)) dut_s (
        .clk(clk), .reset(reset), .load(load), .load_data(ldd), .incr(incr), .decr(decr),
        .count(cnt_s), .at_min(amin_s), .at_max(amax_s), .wrapped(wr_s), .load_err(le_s));

    c_mod_counter_mc #(.num_channels(2), .width(3), .min_value(0), .max_value(7),
                       .reset_value(0), .sat_mode(0)) dut_p (
        .clk(clk), .reset(reset), .load(load), .load_data(ldd_p), .incr(incr), .decr(decr),
        .count(cnt_p), .at_min(amin_p), .at_max(amax_p), .wrapped(wr_p), .load_err(le_p));

    // Entry index is d*2+c: d selects the bank (0 wrap, 1 sat, 2 pow2).
    typedef struct packed {
        logic [23:0] cnt;
        logic [5:0]  amin;
        logic [5:0]  amax;
        logic [5:0]  wr;
        logic [5:0]  le;
    } exp_t;

    exp_t q[$];
    int   mc[3][2];
    int   mn[3]  = '{3, 3, 0};
    int   mx[3]  = '{9, 9, 7};
    bit   sat[3] = '{1'b0, 1'b1, 1'b0};
    int   n_cmp  = 0;
    int   n_err  = 0;

    // Behavioural reference: counting happens modulo the range size.
    function automatic void mstep(input int cnt, input bit ld, input int ldv, input bit inc,
                                  input bit dec, input int lo, input int hi, input bit s,
                                  output int nc, output bit w, output bit le);
        int range;
        range = hi - lo + 1;
        nc = cnt; w = 1'b0; le = 1'b0;
        if (ld) begin
            if (ldv < lo || ldv > hi) begin
                nc = lo; le = 1'b1;
            end else begin
                nc = ldv;
            end
        end else if (inc && !dec) begin
            w  = (cnt == hi);
            nc = (s && w) ? cnt : lo + ((cnt - lo + 1) % range);
        end else if (dec && !inc) begin
            w  = (cnt == lo);
            nc = (s && w) ? cnt : lo + ((cnt - lo - 1 + range) % range);
        end
    endfunction

    function automatic exp_t expect_state(input bit [5:0] wrs, input bit [5:0] les);
        exp_t e;
        e = '0;
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < 2; c++) begin
                e.cnt[(d*2+c)*4 +: 4] = mc[d][c][3:0];
                e.amin[d*2+c]         = (mc[d][c] == mn[d]);
                e.amax[d*2+c]         = (mc[d][c] == mx[d]);
            end
        end
        e.wr = wrs;
        e.le = les;
        return e;
    endfunction

    function automatic exp_t actual();
        exp_t a;
        a.cnt  = {1'b0, cnt_p[5:3], 1'b0, cnt_p[2:0], cnt_s, cnt_w};
        a.amin = {amin_p, amin_s, amin_w};
        a.amax = {amax_p, amax_s, amax_w};
        a.wr   = {wr_p, wr_s, wr_w};
        a.le   = {le_p, le_s, le_w};
        return a;
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
        end
    endtask

    task automatic compare(input string tag, input exp_t a, input exp_t e);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s bank%0d ch%0d count", tag, i/2, i%2),
                int'(a.cnt[i*4 +: 4]), int'(e.cnt[i*4 +: 4]));
            chk($sformatf("%s bank%0d ch%0d at_min", tag, i/2, i%2), int'(a.amin[i]), int'(e.amin[i]));
            chk($sformatf("%s bank%0d ch%0d at_max", tag, i/2, i%2), int'(a.amax[i]), int'(e.amax[i]));
            chk($sformatf("%s bank%0d ch%0d wrapped", tag, i/2, i%2), int'(a.wr[i]), int'(e.wr[i]));
            chk($sformatf("%s bank%0d ch%0d load_err", tag, i/2, i%2), int'(a.le[i]), int'(e.le[i]));
        end
    endtask

    // Drive one cycle of stimulus and push the expected post-edge state.
    task automatic cyc(input logic [1:0] l, input logic [7:0] d, input logic [1:0] i,
                       input logic [1:0] dd);
        bit [5:0] wrs, les;
        int       ldv, nc;
        bit       w, le;
        @(negedge clk);
        load = l; ldd = d; incr = i; decr = dd;
        wrs = '0; les = '0;
        for (int b = 0; b < 3; b++) begin
            for (int c = 0; c < 2; c++) begin
                ldv = (b == 2) ? int'(d[c*4 +: 3]) : int'(d[c*4 +: 4]);
                mstep(mc[b][c], l[c], ldv, i[c], dd[c], mn[b], mx[b], sat[b], nc, w, le);
                mc[b][c]      = nc;
                wrs[b*2+c]    = w;
                les[b*2+c]    = le;
            end
        end
        q.push_back(expect_state(wrs, les));
    endtask

    // Assert reset away from any clock edge and check the async response.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 reset = 1'b1;
        load = '0; incr = '0; decr = '0;
        for (int b = 0; b < 3; b++) begin
            for (int c = 0; c < 2; c++) mc[b][c] = mn[b];
        end
        #1 compare(tag, actual(), expect_state('0, '0));
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                compare("sb", actual(), e);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        for (int b = 0; b < 3; b++) begin
            for (int c = 0; c < 2; c++) mc[b][c] = mn[b];
        end
        repeat (2) @(negedge clk);
        compare("por", actual(), expect_state('0, '0));
        reset = 1'b0;

        repeat (4) cyc(2'b00, 8'h00, 2'b01, 2'b00);   // ch0 up to 7
        do_reset("async_reset");

        repeat (8) cyc(2'b00, 8'h00, 2'b01, 2'b00);   // wrap at 9 / pow2 wrap at 7
        cyc(2'b00, 8'h00, 2'b00, 2'b00);

        cyc(2'b00, 8'h00, 2'b00, 2'b10);              // ch1 decr at min
        cyc(2'b00, 8'h00, 2'b00, 2'b00);

        cyc(2'b01, 8'h0C, 2'b01, 2'b00);              // out-of-range load beats incr
        cyc(2'b01, 8'h06, 2'b00, 2'b00);

        cyc(2'b01, 8'h09, 2'b00, 2'b00);
        cyc(2'b00, 8'h00, 2'b11, 2'b01);              // ch0 incr&decr hold, ch1 incr
        cyc(2'b10, 8'hF0, 2'b00, 2'b00);              // ch1 out-of-range high nibble
        cyc(2'b11, 8'h92, 2'b00, 2'b00);              // ch0 below min, ch1 at max

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(63) == 0) begin
                do_reset("rand_reset");
            end else begin
                cyc({($urandom_range(7) == 0), ($urandom_range(7) == 0)},
                    8'($urandom), 2'($urandom), 2'($urandom));
            end
        end

        repeat (3) @(negedge clk);
        chk("scoreboard drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_c_mod_counter_mc
`default_nettype wire
